// File: rtl/neuron_o_backprop.sv
// ---------------------------------------------------------------------------
// neuron_o_backprop
//
// Backward pass for the two-input output neuron. From the forward result y,
// the target and the two hidden activations it forms the output delta
//     delta = (y - target) * (1 - y*y)
// and then applies one gradient-descent step to the neuron's parameters:
//     w_1 -= lr*delta*a_1,  w_2 -= lr*delta*a_2,  b -= lr*delta
// All values are signed fixed point with FBITS fractional bits. A single
// multiplier is shared across the step by a 7-state FSM.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   en                       clock enable for every register, FSM included
//   load, w_1_in/w_2_in/b_in parameter preload, accepted in IDLE only
//   start                    begin one training step, accepted in IDLE only
//   a_1, a_2, y, target, lr  step operands, captured when start is accepted
//   w_1, w_2, b              current parameters
//   delta                    most recent output delta
//   busy                     high while a step is in progress
//   done                     one-enabled-cycle pulse after the bias update
// ---------------------------------------------------------------------------
module neuron_o_backprop #(
    parameter int WIDTH = 32,
    parameter int FBITS = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] w_1_in,
    input  logic [WIDTH-1:0] w_2_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             start,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] lr,
    output logic [WIDTH-1:0] w_1,
    output logic [WIDTH-1:0] w_2,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] delta,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] S_YY  = 3'd1;
    localparam logic [2:0] S_DEL = 3'd2;
    localparam logic [2:0] S_LD  = 3'd3;
    localparam logic [2:0] S_W1  = 3'd4;
    localparam logic [2:0] S_W2  = 3'd5;
    localparam logic [2:0] S_B   = 3'd6;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FBITS;

    // Parameter update: p - x, clamped to the most positive / most negative
    // word when the true difference does not fit.
    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0] x);
        logic [WIDTH:0] diff;
        diff = {p[WIDTH-1], p} - {x[WIDTH-1], x};
        if (diff[WIDTH] != diff[WIDTH-1])
            sat_sub = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat_sub = diff[WIDTH-1:0];
    endfunction

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] w_1_q, w_1_d;
    logic [WIDTH-1:0] w_2_q, w_2_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] delta_q, delta_d;
    logic [WIDTH-1:0] a_1_q, a_1_d;
    logic [WIDTH-1:0] a_2_q, a_2_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] lr_q, lr_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic             done_q, done_d;

    // Shared multiplier: operands are steered by the current state.
    logic signed [WIDTH-1:0]   mul_a, mul_b;
    logic signed [2*WIDTH-1:0] mul_prod;
    logic        [WIDTH-1:0]   mul_res;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_YY:  begin mul_a = $signed(y_q);  mul_b = $signed(y_q);     end
            S_DEL: begin mul_a = $signed(e_q);  mul_b = $signed(d_q);     end
            S_LD:  begin mul_a = $signed(lr_q); mul_b = $signed(delta_q); end
            S_W1:  begin mul_a = $signed(ld_q); mul_b = $signed(a_1_q);   end
            S_W2:  begin mul_a = $signed(ld_q); mul_b = $signed(a_2_q);   end
            default: begin mul_a = '0; mul_b = '0; end
        endcase
        mul_prod = mul_a * mul_b;
        // Truncating shift, no rounding; result wraps to WIDTH bits.
        mul_res  = WIDTH'(mul_prod >>> FBITS);
    end

    always_comb begin
        state_d = state_q;
        w_1_d   = w_1_q;
        w_2_d   = w_2_q;
        b_d     = b_q;
        delta_d = delta_q;
        a_1_d   = a_1_q;
        a_2_d   = a_2_q;
        y_d     = y_q;
        lr_d    = lr_q;
        e_d     = e_q;
        d_d     = d_q;
        ld_d    = ld_q;
        done_d  = (state_q == S_B);

        case (state_q)
            IDLE: begin
                // load has priority; a simultaneous start is discarded.
                if (load) begin
                    w_1_d = w_1_in;
                    w_2_d = w_2_in;
                    b_d   = b_in;
                end else if (start) begin
                    a_1_d   = a_1;
                    a_2_d   = a_2;
                    y_d     = y;
                    lr_d    = lr;
                    e_d     = y - target;
                    state_d = S_YY;
                end
            end
            S_YY: begin
                d_d     = ONE - mul_res;
                state_d = S_DEL;
            end
            S_DEL: begin
                delta_d = mul_res;
                state_d = S_LD;
            end
            S_LD: begin
                ld_d    = mul_res;
                state_d = S_W1;
            end
            S_W1: begin
                w_1_d   = sat_sub(w_1_q, mul_res);
                state_d = S_W2;
            end
            S_W2: begin
                w_2_d   = sat_sub(w_2_q, mul_res);
                state_d = S_B;
            end
            S_B: begin
                b_d     = sat_sub(b_q, ld_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            w_1_q   <= '0;
            w_2_q   <= '0;
            b_q     <= '0;
            delta_q <= '0;
            a_1_q   <= '0;
            a_2_q   <= '0;
            y_q     <= '0;
            lr_q    <= '0;
            e_q     <= '0;
            d_q     <= '0;
            ld_q    <= '0;
            done_q  <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            w_1_q   <= w_1_d;
            w_2_q   <= w_2_d;
            b_q     <= b_d;
            delta_q <= delta_d;
            a_1_q   <= a_1_d;
            a_2_q   <= a_2_d;
            y_q     <= y_d;
            lr_q    <= lr_d;
            e_q     <= e_d;
            d_q     <= d_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
        end
    end

    assign w_1   = w_1_q;
    assign w_2   = w_2_q;
    assign b     = b_q;
    assign delta = delta_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_neuron_o_backprop.sv
// ---------------------------------------------------------------------------
// tb_neuron_o_backprop
//
// Directed bench for neuron_o_backprop. Expected values are worked out by
// hand in Q8.24 and written as constants next to each step.
// ---------------------------------------------------------------------------
module tb_neuron_o_backprop;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [31:0] w_1_in, w_2_in, b_in;
    logic        start;
    logic [31:0] a_1, a_2, y, target, lr;
    logic [31:0] w_1, w_2, b, delta;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_o_backprop #(.WIDTH(32), .FBITS(24)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .load   (load),
        .w_1_in (w_1_in),
        .w_2_in (w_2_in),
        .b_in   (b_in),
        .start  (start),
        .a_1    (a_1),
        .a_2    (a_2),
        .y      (y),
        .target (target),
        .lr     (lr),
        .w_1    (w_1),
        .w_2    (w_2),
        .b      (b),
        .delta  (delta),
        .busy   (busy),
        .done   (done)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            $display("check %-14s observed=%h expected=%h", tag, obs, exp);
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [31:0] ia1, input logic [31:0] ia2,
                              input logic [31:0] iy, input logic [31:0] itg,
                              input logic [31:0] ilr);
        a_1 = ia1; a_2 = ia2; y = iy; target = itg; lr = ilr;
    endtask

    task automatic do_load(input logic [31:0] iw1, input logic [31:0] iw2,
                           input logic [31:0] ib);
        w_1_in = iw1; w_2_in = iw2; b_in = ib; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // One training step from E0 to E6. Operands are scrambled after E0 to
    // show they were captured. stall_len>0 drops en for that many edges
    // while in S_DEL; collide pulses load and start mid-step.
    task automatic do_step(input int stall_len, input bit collide);
        start = 1'b1;
        tick();                                     // E0
        start = 1'b0;
        set_inputs(32'h1234_5678, 32'h8765_4321, 32'h7000_0000,
                   32'h9000_0000, 32'h3333_3333);
        chk("busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2 && stall_len > 0) begin
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk("stall_busy", {31'd0, busy}, 32'd1);
                    chk("stall_done", {31'd0, done}, 32'd0);
                end
                en = 1'b1;
            end
            if (k == 3 && collide) begin
                load = 1'b1; start = 1'b1;
                w_1_in = 32'h0BAD_0001; w_2_in = 32'h0BAD_0002; b_in = 32'h0BAD_0003;
            end
            tick();                                 // E1..E5
            load = 1'b0; start = 1'b0;
            chk("busy_mid", {31'd0, busy}, 32'd1);
            chk("done_mid", {31'd0, done}, 32'd0);
        end
        tick();                                     // E6
        chk("done_e6", {31'd0, done}, 32'd1);
        chk("busy_e6", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; start = 1'b0;
        w_1_in = '0; w_2_in = '0; b_in = '0;
        set_inputs('0, '0, '0, '0, '0);
        tick(); tick();
        chk("rst_w1", w_1, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Nominal step: delta=0.375, ld=0.1875.
        do_load(32'h0080_0000, 32'hFFC0_0000, 32'h0020_0000);
        chk("load_w1", w_1, 32'h0080_0000);
        chk("load_w2", w_2, 32'hFFC0_0000);
        chk("load_b", b, 32'h0020_0000);
        chk("load_busy", {31'd0, busy}, 32'd0);
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0080_0000);
        do_step(0, 1'b0);
        chk("nom_delta", delta, 32'h0060_0000);
        chk("nom_w1", w_1, 32'h0050_0000);
        chk("nom_w2", w_2, 32'hFFA8_0000);
        chk("nom_b", b, 32'hFFF0_0000);
        tick();
        chk("nom_done_e7", {31'd0, done}, 32'd0);

        // Zero error: parameters unchanged.
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000);
        do_step(0, 1'b0);
        chk("zero_delta", delta, 32'h0);
        chk("zero_w1", w_1, 32'h0050_0000);
        chk("zero_w2", w_2, 32'hFFA8_0000);
        chk("zero_b", b, 32'hFFF0_0000);
        tick();

        // Enable stall of 5 edges in S_DEL; same result as nominal.
        do_load(32'h0080_0000, 32'hFFC0_0000, 32'h0020_0000);
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0080_0000);
        do_step(5, 1'b0);
        chk("stall_delta", delta, 32'h0060_0000);
        chk("stall_w1", w_1, 32'h0050_0000);
        chk("stall_w2", w_2, 32'hFFA8_0000);
        chk("stall_b", b, 32'hFFF0_0000);
        // done holds while en is low.
        en = 1'b0;
        tick(); tick();
        chk("done_hold", {31'd0, done}, 32'd1);
        en = 1'b1;
        tick();
        chk("done_clear", {31'd0, done}, 32'd0);

        // Saturation: ld = 127 * -0.375 = -47.625, b + 47.625 overflows.
        do_load(32'h0, 32'h0, 32'h7FF0_0000);
        set_inputs(32'h0, 32'h0, 32'h0080_0000, 32'h0100_0000, 32'h7F00_0000);
        do_step(0, 1'b0);
        chk("sat_delta", delta, 32'hFFA0_0000);
        chk("sat_b", b, 32'h7FFF_FFFF);
        chk("sat_w1", w_1, 32'h0);
        tick();

        // Collisions: load+start in IDLE -> load only.
        w_1_in = 32'h0080_0000; w_2_in = 32'hFFC0_0000; b_in = 32'h0020_0000;
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0080_0000);
        load = 1'b1; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        chk("coll_busy", {31'd0, busy}, 32'd0);
        chk("coll_w1", w_1, 32'h0080_0000);
        chk("coll_b", b, 32'h0020_0000);
        tick();
        chk("coll_busy2", {31'd0, busy}, 32'd0);
        // load/start while busy are ignored.
        do_step(0, 1'b1);
        chk("collb_w1", w_1, 32'h0050_0000);
        chk("collb_w2", w_2, 32'hFFA8_0000);
        chk("collb_b", b, 32'hFFF0_0000);
        tick();
        chk("collb_noq", {31'd0, busy}, 32'd0);

        // Async reset mid-S_W2 (E4 done), asserted between edges.
        do_load(32'h0080_0000, 32'hFFC0_0000, 32'h0020_0000);
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0080_0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_w1", w_1, 32'h0);
        chk("arst_w2", w_2, 32'h0);
        chk("arst_b", b, 32'h0);
        chk("arst_delta", delta, 32'h0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        tick();
        rst = 1'b0;
        // Fresh step from zero parameters: w_1=-0.1875, w_2=-0.09375, b=-0.1875.
        set_inputs(32'h0100_0000, 32'h0080_0000, 32'h0080_0000, 32'h0, 32'h0080_0000);
        do_step(0, 1'b0);
        chk("post_delta", delta, 32'h0060_0000);
        chk("post_w1", w_1, 32'hFFD0_0000);
        chk("post_w2", w_2, 32'hFFE8_0000);
        chk("post_b", b, 32'hFFD0_0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
